// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO.
// Queued words go out as back-to-back frames with no idle gap between them.
module uart_tx_fifo #(
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        TX,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic                        overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(BAUD_DIV + 1);
  localparam int unsigned NW = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic [2:0]        state;
  logic [BW-1:0]     baud_cnt;
  logic [NW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;

  logic [2:0]        state_n;
  logic [BW-1:0]     baud_n;
  logic [NW-1:0]     bit_n;
  logic [DATA_W-1:0] shreg_n;
  logic              par_n;
  logic              tx_n;
  logic              done_n;
  logic              pop_c;
  logic              push_c;
  logic              tick_c;
  logic [DATA_W-1:0] head_c;
  logic              head_par_c;
  logic [CW-1:0]     count_n;

  // Push acceptance is judged on the registered full flag only.
  assign push_c     = wr_en && !full && !rst;
  assign tick_c     = (baud_cnt == BW'(BAUD_DIV - 1));
  assign head_c     = mem[rd_ptr];
  assign head_par_c = (PARITY == 2) ? ~(^head_c) : (^head_c);

  // Next-state and registered-output values for the transmit FSM.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    par_n   = par_bit;
    tx_n    = TX;
    done_n  = 1'b0;
    pop_c   = 1'b0;
    case (state)
      S_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        if (!empty) begin
          pop_c   = 1'b1;
          state_n = S_START;
          shreg_n = head_c;
          par_n   = head_par_c;
          tx_n    = 1'b0;
        end
      end
      S_START: begin
        if (tick_c) begin
          state_n = S_DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      S_DATA: begin
        if (tick_c) begin
          baud_n = '0;
          if (bit_cnt == NW'(DATA_W - 1)) begin
            bit_n = '0;
            if (PARITY != 0) begin
              state_n = S_PAR;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n   = bit_cnt + 1'b1;
            shreg_n = shreg >> 1;
            tx_n    = shreg_n[0];
          end
        end
      end
      S_PAR: begin
        if (tick_c) begin
          state_n = S_STOP;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick_c) begin
          baud_n = '0;
          if (bit_cnt == NW'(STOP_BITS - 1)) begin
            done_n = 1'b1;
            bit_n  = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (!empty) begin
              pop_c   = 1'b1;
              state_n = S_START;
              shreg_n = head_c;
              par_n   = head_par_c;
              tx_n    = 1'b0;
            end else begin
              state_n = S_IDLE;
              tx_n    = 1'b1;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_n = count;
    if (push_c && !pop_c) begin
      count_n = count + CW'(1);
    end else if (pop_c && !push_c) begin
      count_n = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      overflow <= 1'b0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_bit  <= par_n;
      TX       <= tx_n;
      tx_busy  <= (state_n != S_IDLE);
      tx_done  <= done_n;
      overflow <= wr_en && full;
      count    <= count_n;
      full     <= (count_n == CW'(FIFO_DEPTH));
      empty    <= (count_n == '0);
      if (push_c) wr_ptr <= wr_ptr + 1'b1;
      if (pop_c)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four parameterisations, directed words,
// per-instance frame monitors popping hand-computed expectations.
module tb_uart_tx_fifo;

  localparam int unsigned NI = 4;
  localparam int unsigned BD_A  [NI] = '{4, 3, 4, 2604};
  localparam int unsigned PAR_A [NI] = '{0, 1, 2, 0};
  localparam int unsigned SB_A  [NI] = '{1, 2, 1, 1};

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
    logic       par;
    logic       b2b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       wr_en_s   [NI];
  logic [7:0] wr_data_s [NI];
  logic       tx_s      [NI];
  logic       full_s    [NI];
  logic       empty_s   [NI];
  logic [3:0] count_s   [NI];
  logic       busy_s    [NI];
  logic       done_s    [NI];
  logic       ovf_s     [NI];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   found;
  int   viol;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned BD  = BD_A[g];
    localparam int unsigned PAR = PAR_A[g];
    localparam int unsigned SB  = SB_A[g];
    localparam int unsigned NB  = 9 + ((PAR != 0) ? 1 : 0) + SB;

    uart_tx_fifo #(
      .BAUD_DIV(BD), .DATA_W(8), .FIFO_DEPTH(8), .PARITY(PAR), .STOP_BITS(SB)
    ) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en_s[g]), .wr_data(wr_data_s[g]),
      .TX(tx_s[g]), .full(full_s[g]), .empty(empty_s[g]), .count(count_s[g]),
      .tx_busy(busy_s[g]), .tx_done(done_s[g]), .overflow(ovf_s[g])
    );

    // Frame monitor: decodes each frame from TX and compares it with the scoreboard head.
    initial begin : mon
      exp_t        e;
      logic [11:0] bits;
      int          bad;
      bit          chained;
      bit          aborted;
      bit          stray;
      chained = 1'b0;
      stray   = 1'b0;
      forever begin
        if (!chained) begin
          @(negedge clk);
          while (rst !== 1'b0 || tx_s[g] !== 1'b0) begin
            if (rst === 1'b1) stray = 1'b0;
            else if (done_s[g] === 1'b1) stray = 1'b1;
            @(negedge clk);
          end
        end
        check($sformatf("mon%0d_frame_expected", g), 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else e = '{idx: 2'(g), data: 8'h00, par: 1'b0, b2b: 1'b0};
        check($sformatf("mon%0d_instance", g), 32'(e.idx), 32'(g));
        check($sformatf("mon%0d_no_idle_gap", g), 32'(chained), 32'(e.b2b));
        check($sformatf("mon%0d_stray_tx_done", g), 32'(stray), 32'd0);
        bits      = '1;
        bits[0]   = 1'b0;
        bits[8:1] = e.data;
        if (PAR != 0) bits[9] = e.par;
        bad     = 0;
        aborted = 1'b0;
        for (int n = 0; n < int'(NB * BD); n++) begin
          if (n != 0) @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx_s[g] !== bits[n / int'(BD)]) bad++;
          if (n != 0 && done_s[g] !== 1'b0) bad++;
          if (busy_s[g] !== 1'b1) bad++;
        end
        chained = 1'b0;
        stray   = 1'b0;
        if (!aborted) begin
          check($sformatf("mon%0d_frame_%02h_bits", g, e.data), 32'(bad), 32'd0);
          @(negedge clk);
          check($sformatf("mon%0d_tx_done_at_end", g), 32'(done_s[g]), 32'd1);
          chained = (rst === 1'b0 && tx_s[g] === 1'b0);
        end
      end
    end
  end

  task automatic expect_frame(input int i, input logic [7:0] d, input logic p, input logic b);
    exp_q.push_back('{idx: 2'(i), data: d, par: p, b2b: b});
  endtask

  // Called just after a rising edge; the word is sampled at the next one.
  task automatic push(input int i, input logic [7:0] d);
    wr_en_s[i]   = 1'b1;
    wr_data_s[i] = d;
    @(posedge clk);
    #1;
    wr_en_s[i] = 1'b0;
  endtask

  task automatic wait_drain(input int i, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy_s[i] !== 1'b0 || empty_s[i] !== 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("drain%0d_in_budget", i), 32'(n < budget), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < int'(NI); i++) begin
      wr_en_s[i]   = 1'b0;
      wr_data_s[i] = 8'h00;
    end
    // A write during reset must be dropped.
    wr_en_s[0]   = 1'b1;
    wr_data_s[0] = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", 32'(tx_s[0]), 32'd1);
    check("rst_busy", 32'(busy_s[0]), 32'd0);
    check("rst_done", 32'(done_s[0]), 32'd0);
    check("rst_overflow", 32'(ovf_s[0]), 32'd0);
    check("rst_full", 32'(full_s[0]), 32'd0);
    check("rst_empty", 32'(empty_s[0]), 32'd1);
    check("rst_count", 32'(count_s[0]), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    wr_en_s[0] = 1'b0;
    @(negedge clk);
    check("post_rst_count", 32'(count_s[0]), 32'd0);
    check("post_rst_tx", 32'(tx_s[0]), 32'd1);
    @(posedge clk);
    #1;

    // Single word: TX falls one edge after the push.
    expect_frame(0, 8'h67, 1'b0, 1'b0);
    push(0, 8'h67);
    @(negedge clk);
    check("lat_count_after_push", 32'(count_s[0]), 32'd1);
    check("lat_empty_after_push", 32'(empty_s[0]), 32'd0);
    check("lat_tx_still_idle", 32'(tx_s[0]), 32'd1);
    @(negedge clk);
    check("lat_tx_fall", 32'(tx_s[0]), 32'd0);
    check("lat_busy", 32'(busy_s[0]), 32'd1);
    check("lat_count_after_pop", 32'(count_s[0]), 32'd0);
    wait_drain(0, 200);

    // Two consecutive pushes: frames chained, FIFO empty after the second pop.
    expect_frame(0, 8'h67, 1'b0, 1'b0);
    expect_frame(0, 8'h73, 1'b0, 1'b1);
    push(0, 8'h67);
    push(0, 8'h73);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (done_s[0] === 1'b1) found = 1'b1;
    end
    check("b2b_first_done_seen", 32'(found), 32'd1);
    check("b2b_empty_after_pop2", 32'(empty_s[0]), 32'd1);
    wait_drain(0, 200);

    // Fill while a frame is on the line; the 9th push overflows, pointers wrap.
    expect_frame(0, 8'h11, 1'b0, 1'b0);
    push(0, 8'h11);
    @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) begin
      expect_frame(0, 8'(8'h20 + i), 1'b0, 1'b1);
      push(0, 8'(8'h20 + i));
    end
    @(negedge clk);
    check("fill_full", 32'(full_s[0]), 32'd1);
    check("fill_count", 32'(count_s[0]), 32'd8);
    @(posedge clk);
    #1;
    push(0, 8'h99);
    @(negedge clk);
    check("ovf_pulse", 32'(ovf_s[0]), 32'd1);
    check("ovf_count_kept", 32'(count_s[0]), 32'd8);
    @(negedge clk);
    check("ovf_one_cycle", 32'(ovf_s[0]), 32'd0);
    // The 0x11 frame started one edge after its push and lasts 40 cycles:
    // present a push on exactly the edge that pops the next word.
    repeat (28) @(posedge clk);
    #1;
    push(0, 8'h98);
    @(negedge clk);
    check("pushpop_ovf", 32'(ovf_s[0]), 32'd1);
    check("pushpop_count", 32'(count_s[0]), 32'd7);
    check("pushpop_full_clear", 32'(full_s[0]), 32'd0);
    check("pushpop_aligned_done", 32'(done_s[0]), 32'd1);
    wait_drain(0, 600);

    // Reset during data bit 3 with three words queued.
    expect_frame(0, 8'h5A, 1'b0, 1'b0);
    push(0, 8'h5A);
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("midrst_count_before", 32'(count_s[0]), 32'd3);
    check("midrst_bit3_value", 32'(tx_s[0]), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_tx", 32'(tx_s[0]), 32'd1);
    check("midrst_count", 32'(count_s[0]), 32'd0);
    check("midrst_busy", 32'(busy_s[0]), 32'd0);
    check("midrst_empty", 32'(empty_s[0]), 32'd1);
    viol = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_s[0] !== 1'b1 || done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) viol++;
    end
    check("midrst_quiet_line", 32'(viol), 32'd0);
    @(posedge clk);
    #1;
    expect_frame(0, 8'hA5, 1'b0, 1'b0);
    push(0, 8'hA5);
    wait_drain(0, 200);

    // Even parity, two stop bits: 0x73 -> 1, 0x0F -> 0.
    expect_frame(1, 8'h73, 1'b1, 1'b0);
    expect_frame(1, 8'h0F, 1'b0, 1'b1);
    push(1, 8'h73);
    push(1, 8'h0F);
    wait_drain(1, 200);

    // Odd parity: 0x67 -> 0, 0x00 -> 1.
    expect_frame(2, 8'h67, 1'b0, 1'b0);
    expect_frame(2, 8'h00, 1'b1, 1'b1);
    push(2, 8'h67);
    push(2, 8'h00);
    wait_drain(2, 200);

    // Default timing: 2604 cycles per bit, tx_done 26040 cycles after the fall.
    expect_frame(3, 8'h67, 1'b0, 1'b0);
    push(3, 8'h67);
    wait_drain(3, 27000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
